// File: rtl/issue_queue_nw_pkg.sv
// Shared issue-queue constants and the default-width entry layout.
// Payload is kept outside the entry struct so the select/wakeup logic never touches it.
package issue_queue_nw_pkg;

   localparam int IQ_DEPTH_ALU = 16;
   localparam int IQ_DEPTH_MEM = 16;
   localparam int IQ_DEPTH_Z   = 8;
   localparam int NUM_WB_PORTS = 2;
   localparam int IQ_PREG_W    = 6;
   localparam int IQ_AL_IDX_W  = 5;
   localparam int IQ_PAYLOAD_W = 96;

   typedef struct packed {
      logic                   valid;
      logic                   rs1_rdy;
      logic                   rs2_rdy;
      logic [IQ_PREG_W-1:0]   rs1;
      logic [IQ_PREG_W-1:0]   rs2;
      logic [IQ_AL_IDX_W-1:0] al_idx;
   } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-first arbiter: picks the candidate with the smallest age and returns a one-hot grant.
module iq_age_select #(
   parameter int N     = 16,
   parameter int AGE_W = 5
) (
   input  logic [N-1:0]       cand,
   input  logic [N*AGE_W-1:0] ages,
   output logic [N-1:0]       grant,
   output logic               any
);

   logic [AGE_W-1:0] best;

   // Ages are unique among valid entries, so a strict compare never sees a tie.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      best  = '1;
      for (int i = 0; i < N; i++) begin
         if (cand[i] && (!any || ages[i*AGE_W +: AGE_W] < best)) begin
            grant    = '0;
            grant[i] = 1'b1;
            any      = 1'b1;
            best     = ages[i*AGE_W +: AGE_W];
         end
      end
   end

endmodule

// File: rtl/issue_queue_nw.sv
// Out-of-order issue queue: dispatch into the lowest free slot, wake sources from
// writeback tags, issue the oldest ready µop, and drop squashed entries on flush.
module issue_queue_nw
   import issue_queue_nw_pkg::*;
#(
   parameter int DEPTH     = IQ_DEPTH_ALU,
   parameter int NUM_WB    = NUM_WB_PORTS,
   parameter int PREG_W    = IQ_PREG_W,
   parameter int AL_IDX_W  = IQ_AL_IDX_W,
   parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic                        disp_valid,
   output logic                        disp_ready,
   input  logic                        disp_uses_rs1,
   input  logic                        disp_uses_rs2,
   input  logic [PREG_W-1:0]           disp_rs1,
   input  logic [PREG_W-1:0]           disp_rs2,
   input  logic                        disp_rs1_rdy,
   input  logic                        disp_rs2_rdy,
   input  logic [AL_IDX_W-1:0]         disp_al_idx,
   input  logic [PAYLOAD_W-1:0]        disp_payload,
   input  logic [NUM_WB-1:0]           wb_valid,
   input  logic [NUM_WB-1:0]           wb_uses_rd,
   input  logic [NUM_WB*PREG_W-1:0]    wb_rd,
   input  logic [AL_IDX_W-1:0]         al_head,
   input  logic                        flush_all,
   input  logic                        flush_younger,
   input  logic [AL_IDX_W-1:0]         flush_al_idx,
   output logic                        iss_valid,
   input  logic                        iss_ready,
   output logic [PREG_W-1:0]           iss_rs1,
   output logic [PREG_W-1:0]           iss_rs2,
   output logic [AL_IDX_W-1:0]         iss_al_idx,
   output logic [PAYLOAD_W-1:0]        iss_payload,
   output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic                valid;
      logic                rs1_rdy;
      logic                rs2_rdy;
      logic [PREG_W-1:0]   rs1;
      logic [PREG_W-1:0]   rs2;
      logic [AL_IDX_W-1:0] al_idx;
   } entry_t;

   entry_t                 ent     [DEPTH];
   logic [PAYLOAD_W-1:0]   payload [DEPTH];
   logic [OCC_W-1:0]       occ_q;

   logic [DEPTH-1:0]          wake1, wake2, cand, kill, grant, clr, valid_vec;
   logic [DEPTH*AL_IDX_W-1:0] ages_flat;
   logic                      disp_hit1, disp_hit2;
   logic [AL_IDX_W-1:0]       flush_age, disp_age, age_i;
   logic [IDX_W-1:0]          sel_idx, free_idx;
   logic [OCC_W-1:0]          clr_cnt;
   logic                      disp_wr, iss_fire;

   // Tag match against every qualifying writeback port, for stored entries and the incoming µop.
   always_comb begin
      wake1     = '0;
      wake2     = '0;
      disp_hit1 = 1'b0;
      disp_hit2 = 1'b0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (wb_valid[k] && wb_uses_rd[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent[i].rs1 == wb_rd[k*PREG_W +: PREG_W]) wake1[i] = 1'b1;
               if (ent[i].rs2 == wb_rd[k*PREG_W +: PREG_W]) wake2[i] = 1'b1;
            end
            if (disp_rs1 == wb_rd[k*PREG_W +: PREG_W]) disp_hit1 = 1'b1;
            if (disp_rs2 == wb_rd[k*PREG_W +: PREG_W]) disp_hit2 = 1'b1;
         end
      end
   end

   // Age is distance from the active-list head; modular subtraction absorbs wrap-around.
   assign flush_age = flush_al_idx - al_head;
   assign disp_age  = disp_al_idx - al_head;

   always_comb begin
      ages_flat = '0;
      cand      = '0;
      kill      = '0;
      valid_vec = '0;
      age_i     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age_i                             = ent[i].al_idx - al_head;
         ages_flat[i*AL_IDX_W +: AL_IDX_W] = age_i;
         valid_vec[i] = ent[i].valid;
         cand[i]      = ent[i].valid && ent[i].rs1_rdy && ent[i].rs2_rdy;
         kill[i]      = ent[i].valid && (flush_all || (flush_younger && age_i > flush_age));
      end
   end

   iq_age_select #(.N(DEPTH), .AGE_W(AL_IDX_W)) u_age_select (
      .cand  (cand),
      .ages  (ages_flat),
      .grant (grant),
      .any   (iss_valid)
   );

   // With no grant the index stays 0, so the issue bus shows entry 0.
   always_comb begin
      sel_idx  = '0;
      free_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) sel_idx = IDX_W'(i);
      end
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!ent[i].valid) free_idx = IDX_W'(i);
      end
   end

   assign iss_rs1     = ent[sel_idx].rs1;
   assign iss_rs2     = ent[sel_idx].rs2;
   assign iss_al_idx  = ent[sel_idx].al_idx;
   assign iss_payload = payload[sel_idx];
   assign occupancy   = occ_q;
   assign disp_ready  = (occ_q < OCC_W'(DEPTH));

   assign iss_fire = iss_valid && iss_ready;
   assign disp_wr  = disp_valid && disp_ready && !flush_all
                     && !(flush_younger && disp_age > flush_age);
   // An entry both issued and flushed appears once in clr, so it is freed once.
   assign clr      = kill | (iss_fire ? grant : '0);

   always_comb begin
      clr_cnt = '0;
      for (int i = 0; i < DEPTH; i++) clr_cnt = clr_cnt + OCC_W'(clr[i]);
   end

   // NOTE: state uses non-blocking assignments so every entry sees the same pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         occ_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (clr[i]) begin
               ent[i].valid <= 1'b0;
            end else begin
               if (wake1[i]) ent[i].rs1_rdy <= 1'b1;
               if (wake2[i]) ent[i].rs2_rdy <= 1'b1;
            end
         end
         if (disp_wr) begin
            ent[free_idx] <= '{valid:   1'b1,
                               rs1_rdy: !disp_uses_rs1 || disp_rs1_rdy || disp_hit1,
                               rs2_rdy: !disp_uses_rs2 || disp_rs2_rdy || disp_hit2,
                               rs1:     disp_rs1,
                               rs2:     disp_rs2,
                               al_idx:  disp_al_idx};
         end
         occ_q <= occ_q + OCC_W'(disp_wr) - clr_cnt;
      end
   end

   // NOTE: the payload array is not reset; it is only read through a valid entry.
   always_ff @(posedge clk) begin
      if (disp_wr) payload[free_idx] <= disp_payload;
   end

   a_no_disp_when_full: assert property (@(posedge clk) disable iff (!n_rst)
      disp_wr |-> disp_ready);
   a_occ_matches_valid: assert property (@(posedge clk) disable iff (!n_rst)
      occ_q == OCC_W'($countones(valid_vec)));

endmodule

// File: tb/tb_issue_queue_nw.sv
// Directed bench for issue_queue_nw: wakeup, bypass, age order with wrap, full, flush, reset.
module tb_issue_queue_nw;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        disp_valid = 1'b0;
   logic        disp_ready;
   logic        disp_uses_rs1 = 1'b0, disp_uses_rs2 = 1'b0;
   logic [5:0]  disp_rs1 = '0, disp_rs2 = '0;
   logic        disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
   logic [4:0]  disp_al_idx = '0;
   logic [95:0] disp_payload = '0;
   logic [1:0]  wb_valid = '0, wb_uses_rd = '0;
   logic [11:0] wb_rd = '0;
   logic [4:0]  al_head = '0;
   logic        flush_all = 1'b0, flush_younger = 1'b0;
   logic [4:0]  flush_al_idx = '0;
   logic        iss_valid;
   logic        iss_ready = 1'b0;
   logic [5:0]  iss_rs1, iss_rs2;
   logic [4:0]  iss_al_idx;
   logic [95:0] iss_payload;
   logic [4:0]  occupancy;

   int checks = 0;
   int failures = 0;

   issue_queue_nw dut (
      .clk(clk), .n_rst(n_rst),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_uses_rs1(disp_uses_rs1), .disp_uses_rs2(disp_uses_rs2),
      .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
      .disp_al_idx(disp_al_idx), .disp_payload(disp_payload),
      .wb_valid(wb_valid), .wb_uses_rd(wb_uses_rd), .wb_rd(wb_rd),
      .al_head(al_head),
      .flush_all(flush_all), .flush_younger(flush_younger), .flush_al_idx(flush_al_idx),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_al_idx(iss_al_idx),
      .iss_payload(iss_payload), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [4:0] al, input logic u1, input logic [5:0] r1, input logic rdy1,
                       input logic u2, input logic [5:0] r2, input logic rdy2, input logic [95:0] pl);
      disp_valid    = 1'b1;
      disp_al_idx   = al;
      disp_uses_rs1 = u1;
      disp_rs1      = r1;
      disp_rs1_rdy  = rdy1;
      disp_uses_rs2 = u2;
      disp_rs2      = r2;
      disp_rs2_rdy  = rdy2;
      disp_payload  = pl;
   endtask

   task automatic wb_clear();
      wb_valid   = '0;
      wb_uses_rd = '0;
      wb_rd      = '0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_occ", 128'(occupancy), 128'(0));
      check("rst_iss_valid", 128'(iss_valid), 128'(0));
      check("rst_disp_ready", 128'(disp_ready), 128'(1));
      n_rst = 1'b1;

      // Wakeup through port 1
      disp(5'd3, 1'b1, 6'd10, 1'b0, 1'b0, 6'd0, 1'b0, 96'hA5);
      tick();
      disp_valid = 1'b0;
      #1;
      check("t1_occ", 128'(occupancy), 128'(1));
      check("t1_not_ready", 128'(iss_valid), 128'(0));
      wb_valid = 2'b10; wb_uses_rd = 2'b10; wb_rd = {6'd10, 6'd0};
      #1;
      check("t1_wake_not_same_cycle", 128'(iss_valid), 128'(0));
      tick();
      wb_clear();
      #1;
      check("t1_woken_valid", 128'(iss_valid), 128'(1));
      check("t1_al_idx", 128'(iss_al_idx), 128'(3));
      check("t1_rs1", 128'(iss_rs1), 128'(10));
      check("t1_payload", 128'(iss_payload), 128'(96'hA5));
      iss_ready = 1'b1;
      tick();
      iss_ready = 1'b0;
      #1;
      check("t1_occ_after_issue", 128'(occupancy), 128'(0));
      check("t1_empty", 128'(iss_valid), 128'(0));

      // Wrap-around age ordering
      al_head = 5'd30;
      disp(5'd1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'h1);
      tick();
      disp(5'd31, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'h2);
      tick();
      disp_valid = 1'b0;
      #1;
      check("t2_occ", 128'(occupancy), 128'(2));
      check("t2_first_al", 128'(iss_al_idx), 128'(31));
      check("t2_first_payload", 128'(iss_payload), 128'(96'h2));
      iss_ready = 1'b1;
      tick();
      check("t2_second_al", 128'(iss_al_idx), 128'(1));
      check("t2_occ_mid", 128'(occupancy), 128'(1));
      tick();
      iss_ready = 1'b0;
      #1;
      check("t2_occ_end", 128'(occupancy), 128'(0));

      // Qualified writeback only; then same-cycle dispatch bypass
      al_head = 5'd0;
      disp(5'd4, 1'b1, 6'd7, 1'b0, 1'b0, 6'd0, 1'b0, 96'h44);
      wb_valid = 2'b01; wb_uses_rd = 2'b00; wb_rd = {6'd0, 6'd7};
      tick();
      wb_clear();
      disp_valid = 1'b0;
      #1;
      check("t3_no_uses_rd_no_wake", 128'(iss_valid), 128'(0));
      disp(5'd6, 1'b1, 6'd7, 1'b0, 1'b1, 6'd9, 1'b1, 96'h66);
      wb_valid = 2'b01; wb_uses_rd = 2'b01; wb_rd = {6'd0, 6'd7};
      tick();
      wb_clear();
      disp_valid = 1'b0;
      #1;
      check("t3_both_ready", 128'(iss_valid), 128'(1));
      check("t3_older_first", 128'(iss_al_idx), 128'(4));
      iss_ready = 1'b1;
      tick();
      check("t3_bypass_al", 128'(iss_al_idx), 128'(6));
      check("t3_bypass_rs2", 128'(iss_rs2), 128'(9));
      tick();
      iss_ready = 1'b0;
      #1;
      check("t3_occ_end", 128'(occupancy), 128'(0));

      // Fill to capacity
      for (int i = 0; i < 16; i++) begin
         disp(5'(i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'(i + 256));
         tick();
      end
      disp_valid = 1'b0;
      #1;
      check("t4_full_occ", 128'(occupancy), 128'(16));
      check("t4_full_not_ready", 128'(disp_ready), 128'(0));
      disp(5'd20, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'hDEAD);
      iss_ready = 1'b1;
      #1;
      check("t4_same_cycle_not_ready", 128'(disp_ready), 128'(0));
      check("t4_issue_al", 128'(iss_al_idx), 128'(0));
      tick();
      iss_ready = 1'b0;
      disp_valid = 1'b0;
      #1;
      check("t4_occ_after_issue", 128'(occupancy), 128'(15));
      check("t4_ready_next_cycle", 128'(disp_ready), 128'(1));
      check("t4_next_al", 128'(iss_al_idx), 128'(1));
      check("t4_next_payload", 128'(iss_payload), 128'(96'd257));
      flush_all = 1'b1;
      tick();
      flush_all = 1'b0;
      #1;
      check("t4_flush_all_occ", 128'(occupancy), 128'(0));

      // Younger-than-branch flush
      disp(5'd2, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'h2);
      tick();
      disp(5'd5, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'h5);
      tick();
      disp(5'd8, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'h8);
      tick();
      disp_valid = 1'b0;
      #1;
      check("t5_occ3", 128'(occupancy), 128'(3));
      flush_younger = 1'b1; flush_al_idx = 5'd5;
      tick();
      check("t5_occ_after_flush", 128'(occupancy), 128'(2));
      disp(5'd9, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'h9);
      tick();
      check("t5_younger_disp_dropped", 128'(occupancy), 128'(2));
      disp(5'd4, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'h4);
      tick();
      flush_younger = 1'b0;
      disp_valid = 1'b0;
      #1;
      check("t5_older_disp_kept", 128'(occupancy), 128'(3));
      check("t5_oldest_al", 128'(iss_al_idx), 128'(2));
      flush_all = 1'b1; flush_younger = 1'b1; flush_al_idx = 5'd31; iss_ready = 1'b1;
      disp(5'd10, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'hA);
      #1;
      check("t5_iss_not_gated_by_flush", 128'(iss_valid), 128'(1));
      tick();
      flush_all = 1'b0; flush_younger = 1'b0; iss_ready = 1'b0; disp_valid = 1'b0;
      #1;
      check("t5_issue_flush_freed_once", 128'(occupancy), 128'(0));
      check("t5_empty", 128'(iss_valid), 128'(0));

      // Asynchronous reset mid-traffic
      for (int i = 0; i < 9; i++) begin
         disp(5'(i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 96'(i));
         tick();
      end
      disp_valid = 1'b0;
      #1;
      check("t6_occ9", 128'(occupancy), 128'(9));
      #1;
      n_rst = 1'b0;
      #1;
      check("t6_rst_occ", 128'(occupancy), 128'(0));
      check("t6_rst_iss_valid", 128'(iss_valid), 128'(0));
      check("t6_rst_disp_ready", 128'(disp_ready), 128'(1));
      #2;
      n_rst = 1'b1;
      tick();
      check("t6_post_rst_occ", 128'(occupancy), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/issue_queue_nw.md
Name: issue_queue_nw

Overview:
- Parametrised out-of-order issue queue. Successor to the single-purpose ALU/branch, zero-latency and memory issue-queue bundles.
- Sits between rename/dispatch and one execution pipe. Holds renamed µops with a PAYLOAD_W-bit opaque payload (ALU ctl, imm, branch info, mem type).
- Tracks source readiness via NUM_WB writeback wakeup ports. Issues the oldest ready µop each cycle.
- Removes squashed µops on a full flush or a younger-than-branch flush.

Parameters:
- DEPTH, 16, number of entries (power of 2 not required, ≥2)
- NUM_WB, 2, number of writeback/wakeup ports
- PREG_W, 6, physical register tag width
- AL_IDX_W, 5, active-list index width (= $clog2(AL_SIZE))
- PAYLOAD_W, 96, opaque payload width

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept
- disp_uses_rs1 / disp_uses_rs2  in  1 each  source used
- disp_rs1 / disp_rs2  in  PREG_W each  source tags
- disp_rs1_rdy / disp_rs2_rdy  in  1 each  source ready at rename
- disp_al_idx  in  AL_IDX_W  active-list slot of µop
- disp_payload  in  PAYLOAD_W  opaque payload
- wb_valid  in  NUM_WB  writeback valid per port
- wb_uses_rd  in  NUM_WB  writeback produces a register
- wb_rd  in  NUM_WB*PREG_W  writeback tags, port k at [k*PREG_W +: PREG_W]
- al_head  in  AL_IDX_W  oldest active-list index (age origin)
- flush_all  in  1  kill every entry
- flush_younger  in  1  kill entries strictly younger than flush_al_idx
- flush_al_idx  in  AL_IDX_W  mispredicted branch slot
- iss_valid  out  1  issue offered
- iss_ready  in  1  execution pipe accepts
- iss_rs1 / iss_rs2 / iss_rd-free: iss_rs1, iss_rs2  out  PREG_W each
- iss_al_idx  out  AL_IDX_W
- iss_payload  out  PAYLOAD_W
- occupancy  out  $clog2(DEPTH+1)  valid entry count (registered)

Behaviour:
- Reset: all entry valid bits 0, occupancy 0, iss_valid 0, disp_ready 1.
- Entry state: valid, rs1_rdy, rs2_rdy, tags, al_idx, payload. An unused source is stored as ready.
- disp_ready = (occupancy < DEPTH). This is registered-count based, so a slot freed by issue is not reusable in the same cycle.
- Dispatch: on disp_valid && disp_ready, write the lowest-index free entry at the clock edge.
- Same-cycle bypass: if any wb port k has wb_valid[k] && wb_uses_rd[k] && wb_rd[k] == disp_rsN, the stored rsN_rdy is 1.
- Wakeup: each cycle, every valid entry sets rsN_rdy when any qualifying wb port tag matches. Ready bits never clear.
  - Wakeup takes effect for select the next cycle.
  - Multiple ports matching the same tag is legal.
- Select (combinational):
  - age(i) = (al_idx[i] − al_head) mod 2^AL_IDX_W.
  - Candidates are entries with valid && rs1_rdy && rs2_rdy. Pick the minimum age; al_idx values are unique, so there are no ties.
  - iss_valid = any candidate; iss_* reflect the chosen entry.
  - When iss_valid = 0, iss_* hold the value of entry 0 (don't care).
- Issue: on iss_valid && iss_ready, clear the chosen entry's valid bit at the edge.
  - iss_valid must not depend combinationally on iss_ready.
  - The offer may change between cycles if an older µop becomes ready (no stickiness).
- Flush:
  - flush_all: all valid bits cleared; a same-cycle dispatch is dropped.
  - flush_younger: clear entries with age(i) > age(flush_al_idx). A same-cycle dispatch is written only if its age ≤ age(flush_al_idx).
  - iss_valid is not gated by flush. The pipe kills the issued µop using the same flush signals. An entry issued and flushed in the same cycle is freed once.
  - flush_all has priority over flush_younger.
- occupancy_next = occupancy + dispatched − issued − flushed, where an issued entry is counted once even if it is also flushed. Never exceeds DEPTH.
- Active-list wrap-around is handled solely by the modular age arithmetic.
- Assertions: no dispatch while disp_ready = 0 is accepted; occupancy equals popcount(valid).

Decomposition:
- riscv_pkg gains IQ_DEPTH_ALU/MEM/Z and NUM_WB_PORTS constants, plus a packed iq_entry_t struct (valid, rdy bits, tags, al_idx) with the payload kept separate.
- One sub-module: iq_age_select (DEPTH candidate vector + ages → one-hot grant + any).

Test Plan:
- Reset, dispatch al_idx=3 with rs1=10 not ready, rs2 unused → iss_valid=0. wb_rd=10 on port 1 → iss_valid=1 next cycle, iss_al_idx=3; iss_ready=1 → occupancy 1→0.
- al_head=30, dispatch ready µops al_idx=1, then 31 → issue order 31 then 1 (wrap-around age).
- Dispatch rs1=7 in the same cycle wb_rd=7 on port 0 → entry stored ready, issues the following cycle.
- Fill 16 entries → disp_ready=0, occupancy=16. Issue one → disp_ready=1 the next cycle, not the same cycle.
- al_head=0, entries al_idx 2,5,8, flush_younger with flush_al_idx=5 → 8 removed, occupancy 3→2. flush_all → 0, and a concurrent dispatch is dropped.
- Assert n_rst mid-traffic with 9 entries → immediately occupancy=0, iss_valid=0, disp_ready=1.
